mult_32_seq: RTL and testbench

Sequential 32×32 signed multiplier for the ALU execute stage. It sits beside the combinational shift and add units and writes into the same result path. It runs a radix-2 Booth sequence in 32 iterations. It returns the low 32 bits of the product, an overflow exception, and a one-cycle ready pulse, using the ctrl/data handshake the rest of the multdiv path uses.

---
 rtl/mult_32_seq.sv | 133 +++++++++++++
 tb/tb_mult_32_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_32_seq.sv
// mult_32_seq -- sequential 32x32 signed multiplier (radix-2 Booth, 32 steps)
//
// Purpose:
//   Computes the low 32 bits of the signed product A*B over 32 Booth
//   iterations, flags when the full signed product does not fit in 32 signed
//   bits, and marks completion with a one-cycle ready pulse. Uses the
//   ctrl/data handshake shared with the rest of the multdiv path.
//
// Ports:
//   clock           in   1   rising-edge clock
//   reset_n         in   1   asynchronous active-low reset
//   ctrl_MULT       in   1   start strobe; operands captured on the same edge
//   data_operandA   in  32   multiplicand (two's complement)
//   data_operandB   in  32   multiplier (two's complement)
//   data_result     out 32   low 32 bits of the product, held until next DONE
//   data_exception  out  1   product does not fit in 32 signed bits
//   data_resultRDY  out  1   one-cycle pulse, result/exception valid
//   busy            out  1   high while iterating
//
// States:
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for ctrl_MULT
//   RUN    | one Booth step per cycle, r_cnt counts completed steps
//   DONE   | publish result/exception and pulse ready (single cycle)
//
// A start strobe is honoured in every state: from RUN it aborts the current
// operation (no ready pulse), from DONE it chains the next operation while
// the current result is still published.

module mult_32_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] LAST_STEP = 6'd31;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_m;
  // Product register: {guard, acc[31:0], multiplier[31:0], booth bit}.
  // The accumulator carries one extra sign bit so that adding or subtracting
  // the most negative multiplicand cannot wrap; P[64:1] then holds the exact
  // 64-bit product, which the overflow test relies on.
  logic [65:0] r_p;
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_rdy;

  logic [32:0] w_acc;
  logic [32:0] w_m_ext;
  logic [32:0] w_sum;
  logic [65:0] w_p_next;
  logic [65:0] w_p_load;
  logic        w_fits;

  assign w_acc   = r_p[65:33];
  assign w_m_ext = {r_m[31], r_m};

  always_comb begin
    w_sum = w_acc;
    case (r_p[1:0])
      2'b01:   w_sum = w_acc + w_m_ext;
      2'b10:   w_sum = w_acc - w_m_ext;
      default: w_sum = w_acc;
    endcase
  end

  // Arithmetic right shift of the updated product register.
  assign w_p_next = {w_sum[32], w_sum, r_p[32:1]};
  assign w_p_load = {33'd0, data_operandB, 1'b0};

  // Product bits [63:31] all equal means the value is representable in 32
  // signed bits.
  assign w_fits = (&r_p[64:32]) | (~|r_p[64:32]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 6'd0;
      r_m         <= 32'd0;
      r_p         <= 66'd0;
      r_result    <= 32'd0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;

      if (r_state == S_DONE) begin
        r_result    <= r_p[32:1];
        r_exception <= ~w_fits;
        r_rdy       <= 1'b1;
      end

      if (ctrl_MULT) begin
        r_m     <= data_operandA;
        r_p     <= w_p_load;
        r_cnt   <= 6'd0;
        r_state <= S_RUN;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_RUN: begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LAST_STEP) begin
              r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_mult_32_seq.sv
// Self-checking bench for mult_32_seq: an event-timeline model computes the
// product with 64-bit arithmetic and predicts when each result is published;
// a compare process checks every output on every falling edge, and the
// directed stimulus adds hand-computed literal expectations.

module tb_mult_32_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mult_32_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A start sampled at edge k publishes at edge k+33 unless superseded by a
  // later start or a reset; the unit is busy after edges k..k+31.
  int          edge_n = 0;
  int          m_done_edge = 0;
  int          m_start_edge = 0;
  logic        m_pend = 1'b0;
  longint      m_prod = 0;
  logic [31:0] m_pres = 32'd0;
  logic        m_pexc = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_exc = 1'b0;
  logic        m_rdy = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 1'b0;
      m_res  = 32'd0;
      m_exc  = 1'b0;
      m_rdy  = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_pend && edge_n == m_done_edge) begin
        m_res  = m_pres;
        m_exc  = m_pexc;
        m_rdy  = 1'b1;
        m_pend = 1'b0;
      end
      if (ctrl_MULT) begin
        m_prod       = longint'($signed(op_a)) * longint'($signed(op_b));
        m_pres       = m_prod[31:0];
        m_pexc       = (m_prod > 64'sd2147483647) || (m_prod < -64'sd2147483648);
        m_pend       = 1'b1;
        m_start_edge = edge_n;
        m_done_edge  = edge_n + 33;
      end
      m_busy = m_pend && ((edge_n - m_start_edge) < 32);
      edge_n++;
    end
  end

  always @(negedge clock) begin
    chk("model_result", data_result, m_res);
    chk("model_exception", {31'd0, data_exception}, {31'd0, m_exc});
    chk("model_rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
    chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
  end

  // ---------------- stimulus ----------------
  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = 1'b1;
    op_a = a;
    op_b = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  // Bounded wait for the ready pulse; checks latency, busy length and the
  // literal result/exception.
  task automatic wait_rdy(input string name, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_exc);
    int  lat = 0;
    int  busy_n = 0;
    bit  seen = 0;
    if (busy) busy_n++;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (data_resultRDY) begin
        seen = 1;
        lat  = i;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_n), 32'd32);
    chk({name, "_result"}, data_result, exp_res);
    chk({name, "_exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(negedge clock);
    chk({name, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  logic [31:0] va [8] = '{32'd3, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'd0,
                          32'h00010000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] vb [8] = '{32'd4, 32'd6, 32'd1, 32'h80000000,
                          32'h00010000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
  logic [31:0] vr [8] = '{32'h0000000C, 32'hFFFFFFD6, 32'h7FFFFFFF, 32'd0,
                          32'd0, 32'h80000000, 32'h80000000, 32'd1};
  logic        ve [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int rdy_cnt;
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 8; k++) begin
      start_op(va[k], vb[k]);
      wait_rdy($sformatf("vec%0d", k), 33, vr[k], ve[k]);
    end

    // abort: 5x5 at edge 0 superseded by 2x3 at edge 10
    start_op(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    start_op(32'd2, 32'd3);
    wait_rdy("abort", 33, 32'd6, 1'b0);

    // back-to-back: next start sampled on the DONE edge of 9x9
    start_op(32'd9, 32'd9);
    repeat (32) @(negedge clock);
    chk("b2b_busy_before_done", {31'd0, busy}, 32'd0);
    start_op(32'hFFFFFFFE, 32'd8);
    chk("b2b_first_rdy", {31'd0, data_resultRDY}, 32'd1);
    chk("b2b_first_result", data_result, 32'd81);
    wait_rdy("b2b_second", 33, 32'hFFFFFFF0, 1'b0);

    // reset in the middle of 100x100
    start_op(32'd100, 32'd100);
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_exception", {31'd0, data_exception}, 32'd0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    chk("no_rdy_after_reset", 32'(rdy_cnt), 32'd0);

    // recovery after reset
    start_op(32'd7, 32'hFFFFFFF9);
    wait_rdy("after_reset", 33, 32'hFFFFFFCF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
